// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: dark pattern, active-low
// hex glyph table and digit-enable patterns.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_DARK = 7'h7F;
  localparam logic [3:0] EN_DARK  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} glyphs; entry 15 is first in the packed list.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [3:0] en_onehot_low(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational 4-bit nibble to active-low seven-segment glyph.
module hex7seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-latched display word.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN darkens leading-zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIV_MAX = 50000,
  parameter int DIV_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        value_vld,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic [3:0]  en,
  output logic        frame_done
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       idx;
  logic             frame_bnd;
  logic [15:0]      pending;
  logic [15:0]      shadow;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg;
  logic             digit_lit;

  // >= rather than == so a corrupted count still wraps.
  assign tick      = (div_cnt >= DIV_LAST);
  assign frame_bnd = tick && (idx == 2'd3);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // A strobe on the boundary bypasses pending so it is not lost for a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= 16'h0000;
      shadow     <= 16'h0000;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_bnd;
      if (value_vld) pending <= value;
      if (frame_bnd) shadow <= value_vld ? value : pending;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    nibble    = shadow[{idx, 2'b00} +: 4];
    digit_lit = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    digit_lit = (idx == 2'd0) || ((shadow >> {idx, 2'b00}) != 16'h0000);
`endif
  end

  hex7seg_decode u_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_DARK;
      en  <= EN_DARK;
    end else if (blank || !digit_lit) begin
      seg <= SEG_DARK;
      en  <= EN_DARK;
    end else begin
      seg <= dec_seg;
      en  <= en_onehot_low(idx);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIV_MAX=4, 16-cycle frame) with a
// cycle-count based reference model.
module tb_seg7_scan_driver;

  localparam int DIV_MAX = 4;
  localparam int FRAME   = 4 * DIV_MAX;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [3:0] EN_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        value_vld;
  logic        blank;
  logic [6:0]  seg;
  logic [3:0]  en;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.DIV_MAX(DIV_MAX), .DIV_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .value_vld  (value_vld),
    .blank      (blank),
    .seg        (seg),
    .en         (en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: digit position and frame boundaries follow purely from the
  // number of edges since reset.
  int unsigned k;
  int          m_cur;
  bit          m_bnd;
  bit          m_lit;
  logic [15:0] m_pend, m_shad;
  logic [6:0]  m_seg;
  logic [3:0]  m_en;
  logic        m_fd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; m_pend = 16'h0; m_shad = 16'h0;
      m_seg = 7'h7F; m_en = 4'hF; m_fd = 1'b0;
    end else begin
      m_cur = (k / DIV_MAX) % 4;
      m_bnd = (k % FRAME) == FRAME - 1;
      m_lit = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      m_lit = (m_cur == 0) || ((m_shad >> (4 * m_cur)) != 0);
`endif
      if (blank || !m_lit) begin
        m_seg = 7'h7F; m_en = 4'hF;
      end else begin
        m_seg = HEX[(m_shad >> (4 * m_cur)) & 16'hF];
        m_en  = EN_PAT[m_cur];
      end
      m_fd = m_bnd;
      if (m_bnd) m_shad = value_vld ? value : m_pend;
      if (value_vld) m_pend = value;
      k++;
    end
  end

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < FRAME + 4; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_frame: frame_done not seen within %0d cycles", FRAME + 4);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; value = 16'h0; value_vld = 1'b0; blank = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (seg !== 7'h7F || en !== 4'hF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: seg=%h en=%b fd=%b want 7f 1111 0", seg, en, frame_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== 7'h7F || en !== 4'hF || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: seg=%h en=%b fd=%b want 7f 1111 0", seg, en, frame_done);
      end
    end
    rst = 1'b0;
    for (int j = 0; j < FRAME; j++) begin
      logic [6:0] ws;
      logic [3:0] we;
      @(negedge clk);
      ws = 7'h40; we = EN_PAT[j / DIV_MAX];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (j >= DIV_MAX) begin ws = 7'h7F; we = 4'hF; end
`endif
      checks++;
      if (seg !== ws || en !== we || frame_done !== (j == FRAME - 1)) begin
        errors++;
        $display("FAIL first_frame slot %0d: seg=%h en=%b fd=%b want %h %b %b",
                 j, seg, en, frame_done, ws, we, (j == FRAME - 1));
      end
    end
  endtask

  task automatic test_basic();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
    wait_frame();
    repeat (3) @(negedge clk);
    value = 16'h12AF; value_vld = 1'b1;
    @(negedge clk);
    value_vld = 1'b0;
    wait_frame();
    for (int j = 0; j < 2 * FRAME; j++) begin
      @(negedge clk);
      checks++;
      if (seg !== exp_seg[(j / DIV_MAX) % 4] || en !== EN_PAT[(j / DIV_MAX) % 4] ||
          frame_done !== ((j % FRAME) == FRAME - 1)) begin
        errors++;
        $display("FAIL basic_12AF slot %0d: seg=%h en=%b fd=%b want %h %b %b", j, seg, en,
                 frame_done, exp_seg[(j / DIV_MAX) % 4], EN_PAT[(j / DIV_MAX) % 4],
                 ((j % FRAME) == FRAME - 1));
      end
    end
  endtask

  // Entered right after a frame_done negedge left by test_basic.
  task automatic test_atomic();
    logic [6:0] old_seg [4];
    old_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
    value = 16'h1111; value_vld = 1'b1;
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      value_vld = 1'b0;
      checks++;
      if (seg !== old_seg[j / DIV_MAX] || en !== EN_PAT[j / DIV_MAX]) begin
        errors++;
        $display("FAIL atomic_hold slot %0d: seg=%h en=%b want %h %b", j, seg, en,
                 old_seg[j / DIV_MAX], EN_PAT[j / DIV_MAX]);
      end
      if (j == 7) begin value = 16'h2222; value_vld = 1'b1; end
    end
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      checks++;
      if (seg !== 7'h24 || en !== EN_PAT[j / DIV_MAX]) begin
        errors++;
        $display("FAIL atomic_2222 slot %0d: seg=%h en=%b want 24 %b", j, seg, en,
                 EN_PAT[j / DIV_MAX]);
      end
    end
  endtask

  task automatic test_boundary();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h0E, 7'h06, 7'h06, 7'h03};
    repeat (FRAME - 1) @(negedge clk);
    value = 16'hBEEF; value_vld = 1'b1;
    @(negedge clk);
    value_vld = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL boundary_fd: fd=%b want 1", frame_done);
    end
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      checks++;
      if (seg !== exp_seg[j / DIV_MAX] || en !== EN_PAT[j / DIV_MAX]) begin
        errors++;
        $display("FAIL boundary_BEEF slot %0d: seg=%h en=%b want %h %b", j, seg, en,
                 exp_seg[j / DIV_MAX], EN_PAT[j / DIV_MAX]);
      end
    end
  endtask

  // Entered at a frame_done negedge with shadow=BEEF.
  task automatic test_blank();
    repeat (5) @(negedge clk);
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== 7'h7F || en !== 4'hF || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL blank cycle %0d: seg=%h en=%b fd=%b want 7f 1111 0", i, seg, en,
                 frame_done);
      end
    end
    blank = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || en !== 4'b0111 || seg !== 7'h03) begin
      errors++;
      $display("FAIL blank_resume: fd=%b en=%b seg=%h want 1 0111 03", frame_done, en, seg);
    end
    for (int j = 0; j < DIV_MAX; j++) begin
      @(negedge clk);
      checks++;
      if (en !== 4'b1110 || seg !== 7'h0E || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL blank_next slot %0d: en=%b seg=%h fd=%b want 1110 0e 0", j, en, seg,
                 frame_done);
      end
    end
  endtask

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  task automatic test_lzb();
    logic [15:0] vals [2];
    logic [6:0]  segs [2][4];
    vals = '{16'h0000, 16'h0300};
    segs = '{'{7'h40, 7'h7F, 7'h7F, 7'h7F}, '{7'h40, 7'h40, 7'h30, 7'h7F}};
    for (int v = 0; v < 2; v++) begin
      wait_frame();
      repeat (FRAME - 1) @(negedge clk);
      value = vals[v]; value_vld = 1'b1;
      @(negedge clk);
      value_vld = 1'b0;
      for (int j = 0; j < FRAME; j++) begin
        logic [3:0] we;
        @(negedge clk);
        we = (segs[v][j / DIV_MAX] == 7'h7F) ? 4'hF : EN_PAT[j / DIV_MAX];
        checks++;
        if (seg !== segs[v][j / DIV_MAX] || en !== we) begin
          errors++;
          $display("FAIL lzb %h slot %0d: seg=%h en=%b want %h %b", vals[v], j, seg, en,
                   segs[v][j / DIV_MAX], we);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== m_seg || en !== m_en || frame_done !== m_fd) begin
        errors++;
        $display("FAIL random cycle %0d: seg=%h en=%b fd=%b want %h %b %b", i, seg, en,
                 frame_done, m_seg, m_en, m_fd);
      end
      value     = 16'($urandom);
      value_vld = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) blank = ~blank;
    end
    value_vld = 1'b0;
    blank     = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_atomic();
    test_boundary();
    test_blank();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    test_lzb();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
